// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell
// Combinational one-bit full adder, the only arithmetic in the serial adder.
// Ports:
//   a, b   operand bits
//   cin    carry in
//   s      sum bit
//   co     carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first, using
// a single full-adder cell and a carry flop. Operands arrive on a valid/ready
// port; the registered sum and carry-out leave on a valid/ready port.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, cin)
//   out_valid/out_ready  result handshake (sum, cout)
//   busy                 high while an operation is in flight or held
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh;
    // Holds the WIDTH-1 low sum bits collected so far; the final bit comes
    // straight from the cell when the result register is loaded.
    logic [WIDTH-2:0]   sum_sh;
    logic [WIDTH-1:0]   sum_full;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s, fa_co;
    logic               last_bit;

    full_adder_cell u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    assign sum_full = {fa_s, sum_sh};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: shift registers, carry, counter, result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    sum_sh <= sum_full[WIDTH-1:1];
                    cnt    <= cnt + CNT_W'(1);
                    // Result registers change only here, so they hold the
                    // previous result throughout a new operation.
                    if (last_bit) begin
                        sum_q  <= sum_full;
                        cout_q <= fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed and randomized bench for serial_adder with WIDTH=8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands until accepted; returns one step after the acceptance edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) check("start_timeout", 64'd0, 64'd1);
        a_i      = av;
        b_i      = bv;
        cin_i    = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!out_valid) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic [W:0] exp);
        int lat;
        start_op(av, bv, cv);
        wait_valid(lat);
        check(tag, {cout, sum}, exp);
        tick();
    endtask

    initial begin
        int lat;
        int bad;
        logic [W:0] exp;
        logic [W:0] got;
        logic [W-1:0] ra, rb;
        logic rc;
        logic hs, done, seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_i       = '0;
        b_i       = '0;
        cin_i     = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result", {cout, sum}, 9'h000);
        rst_n = 1'b1;
        tick();

        // Basic add with latency and one-cycle out_valid
        start_op(8'h3C, 8'h0A, 1'b0);
        check("run_in_ready", in_ready, 1'b0);
        check("run_busy", busy, 1'b1);
        wait_valid(lat);
        check("latency", lat, 8);
        check("add_3c_0a", {cout, sum}, 9'h046);
        tick();
        check("valid_one_cycle", out_valid, 1'b0);
        check("ready_after_hs", in_ready, 1'b1);

        // Carry-out cases
        op_check("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
        op_check("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // Backpressure
        out_ready = 1'b0;
        start_op(8'h80, 8'h80, 1'b0);
        wait_valid(lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({cout, sum} !== 9'h100 || !out_valid || in_ready) bad++;
            tick();
        end
        check("bp_hold", bad, 0);
        check("bp_result", {out_valid, cout, sum}, 10'h300);
        out_ready = 1'b1;
        tick();
        check("bp_single_hs", out_valid, 1'b0);
        check("bp_ready_back", in_ready, 1'b1);

        // in_valid held high: second operands wait for the first handshake
        a_i      = 8'h01;
        b_i      = 8'h02;
        cin_i    = 1'b0;
        in_valid = 1'b1;
        tick();
        a_i = 8'h10;
        b_i = 8'h20;
        bad = 0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            if (in_ready) bad++;
            tick();
            lat++;
        end
        check("b2b_no_accept", bad, 0);
        check("b2b_first", {out_valid, cout, sum}, 10'h203);
        tick();
        check("b2b_ready_after_hs", {in_ready, out_valid}, 2'b10);
        tick();
        check("b2b_second_accepted", {in_ready, busy}, 2'b01);
        in_valid = 1'b0;
        wait_valid(lat);
        check("b2b_second", {cout, sum}, 9'h030);
        tick();

        // Reset in the middle of RUN
        start_op(8'hAA, 8'h55, 1'b1);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {in_ready, out_valid, busy, cout, sum}, 12'h800);
        #2;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) bad++;
        end
        check("midrst_no_valid", bad, 0);
        op_check("after_rst_05_07", 8'h05, 8'h07, 1'b0, 9'h00C);

        // Random operands with random backpressure
        for (int k = 0; k < 1000; k++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom_range(0, 1));
            exp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            start_op(ra, rb, rc);
            done = 1'b0;
            seen = 1'b0;
            got  = '0;
            for (int c = 0; c < 60 && !done; c++) begin
                if (out_valid && !seen) begin
                    seen = 1'b1;
                    got  = {cout, sum};
                end
                out_ready = 1'($urandom_range(0, 1));
                hs = out_valid && out_ready;
                tick();
                if (hs) done = 1'b1;
            end
            if (!done) check("rand_timeout", 64'd0, 64'd1);
            check("rand_sum", got, exp);
        end
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
